// File: rtl/id_stage.sv
// Decode stage feeding the ALU: valid/ready input, registered A/B/ALUOp output.
// Optional macro ID_STAGE_ADDI_EN enables ADDI decode (otherwise ADDI is illegal).
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [4:0]      ALUOp,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal,
  output logic [31:0]     dec_count
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LUI   = 5'b00001;
  localparam logic [4:0] OP_AUIPC = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      aluop_q, aluop_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_we_q, rd_we_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     dec_count_q, dec_count_d;

  logic            load, xfer;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val, rs2_val, u_imm;
  logic [4:0]      dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_we, dec_ill;
`ifdef ID_STAGE_ADDI_EN
  logic [XLEN-1:0] i_imm;
`endif

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];

  // x0 reads as zero regardless of what the register file returns
  assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
  assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;
  assign u_imm   = XLEN'($signed({in_instr[31:12], 12'b0}));
`ifdef ID_STAGE_ADDI_EN
  assign i_imm   = XLEN'($signed(in_instr[31:20]));
`endif

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign load     = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    dec_op  = OP_NOP;
    dec_a   = '0;
    dec_b   = '0;
    dec_we  = 1'b0;
    dec_ill = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec_op  = OP_LUI;
        dec_b   = u_imm;
        dec_we  = 1'b1;
        dec_ill = 1'b0;
      end
      OPC_AUIPC: begin
        dec_op  = OP_AUIPC;
        dec_a   = in_pc;
        dec_b   = u_imm;
        dec_we  = 1'b1;
        dec_ill = 1'b0;
      end
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_op  = OP_ADD;
          dec_a   = rs1_val;
          dec_b   = rs2_val;
          dec_we  = 1'b1;
          dec_ill = 1'b0;
        end
      end
`ifdef ID_STAGE_ADDI_EN
      OPC_OPIMM: begin
        if (funct3 == 3'b000) begin
          dec_op  = OP_ADD;
          dec_a   = rs1_val;
          dec_b   = i_imm;
          dec_we  = 1'b1;
          dec_ill = 1'b0;
        end
      end
`else
      OPC_OPIMM: begin
        dec_ill = 1'b1;
      end
`endif
      default: begin
        dec_ill = 1'b1;
      end
    endcase
    if (in_instr[11:7] == 5'd0) begin
      dec_we = 1'b0;
    end
  end

  // Status fields are cleared whenever the stage empties so the ALU sees nop
  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    aluop_d     = aluop_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    dec_count_d = xfer ? dec_count_q + 32'd1 : dec_count_q;
    if (flush || (xfer && !load)) begin
      out_valid_d = 1'b0;
      aluop_d     = OP_NOP;
      rd_we_d     = 1'b0;
      illegal_d   = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      a_d         = dec_a;
      b_d         = dec_b;
      aluop_d     = dec_op;
      rd_d        = in_instr[11:7];
      rd_we_d     = dec_we;
      illegal_d   = dec_ill;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      aluop_q     <= OP_NOP;
      rd_q        <= 5'd0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      dec_count_q <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluop_q     <= aluop_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign ALUOp     = aluop_q;
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;
  assign illegal   = illegal_q;
  assign dec_count = dec_count_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: inputs driven after falling edges, outputs checked at falling edges.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A, B;
  logic [4:0]  ALUOp;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;
  logic [31:0] dec_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .rd(rd), .rd_we(rd_we), .illegal(illegal),
    .dec_count(dec_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                         input logic we, input logic ill);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".ALUOp"}, {27'd0, ALUOp}, {27'd0, op});
    chk({tag, ".A"}, A, a);
    chk({tag, ".B"}, B, b);
    chk({tag, ".rd"}, {27'd0, rd}, {27'd0, r});
    chk({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, we});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ill});
    $display("txn %s: v=%0b op=%0d A=%h B=%h rd=%0d we=%0b ill=%0b cnt=%0d",
             tag, out_valid, ALUOp, A, B, rd, rd_we, illegal, dec_count);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
    rs1_data = 32'h0; rs2_data = 32'h0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_out("reset", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reset.dec_count", dec_count, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    // LUI x1, 0x12345 held under backpressure, then drained
    in_instr = 32'h123450B7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("lui", 1'b1, 5'd1, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0);
    chk("lui.in_ready_full", {31'd0, in_ready}, 32'd0);
    step();
    chk_out("lui_hold", 1'b1, 5'd1, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("lui_drained", 1'b0, 5'd0, 32'h0, 32'h12345000, 5'd1, 1'b0, 1'b0);
    chk("lui.dec_count", dec_count, 32'd1);

    // AUIPC x2, 0x1 at pc 0x100
    in_instr = 32'h00001117; in_pc = 32'h100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("auipc", 1'b1, 5'd2, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0);
    step();
    chk("auipc.dec_count", dec_count, 32'd2);

    // ADD x3,x1,x2 then ADD x3,x0,x2 loaded in the same cycle the first one leaves
    in_instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; in_valid = 1'b1;
    chk("add.rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("add.rs2_addr", {27'd0, rs2_addr}, 32'd2);
    step();
    chk_out("add", 1'b1, 5'd3, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    in_instr = 32'h002001B3; rs1_data = 32'hFFFFFFFF;
    step();
    in_valid = 1'b0;
    chk_out("add_x0", 1'b1, 5'd3, 32'd0, 32'd7, 5'd3, 1'b1, 1'b0);
    chk("add_x0.dec_count", dec_count, 32'd3);
    step();
    chk("add.drain_count", dec_count, 32'd4);

    // Four-instruction stream with a two-cycle stall
    in_instr = 32'h000012B7; in_valid = 1'b1;
    step();
    chk_out("s0", 1'b1, 5'd1, 32'h0, 32'h1000, 5'd5, 1'b1, 1'b0);
    in_instr = 32'hABCDE337;
    step();
    chk_out("s1", 1'b1, 5'd1, 32'h0, 32'hABCDE000, 5'd6, 1'b1, 1'b0);
    in_instr = 32'h00002397; in_pc = 32'h200; out_ready = 1'b0;
    #1;
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk_out("s1_stall1", 1'b1, 5'd1, 32'h0, 32'hABCDE000, 5'd6, 1'b1, 1'b0);
    chk("stall1.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk_out("s1_stall2", 1'b1, 5'd1, 32'h0, 32'hABCDE000, 5'd6, 1'b1, 1'b0);
    chk("stall2.dec_count", dec_count, 32'd5);
    out_ready = 1'b1;
    step();
    chk_out("s2", 1'b1, 5'd2, 32'h200, 32'h2000, 5'd7, 1'b1, 1'b0);
    in_instr = 32'hFFFFF437;
    step();
    chk_out("s3", 1'b1, 5'd1, 32'h0, 32'hFFFFF000, 5'd8, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("stream.dec_count", dec_count, 32'd8);
    chk("stream.out_valid", {31'd0, out_valid}, 32'd0);

    // Illegal word, then ADDI x1, x0, 5
    in_instr = 32'hFFFFFFFF; in_valid = 1'b1;
    step();
    chk_out("illegal", 1'b1, 5'd0, 32'h0, 32'h0, 5'd31, 1'b0, 1'b1);
    in_instr = 32'h00500093; rs1_data = 32'h11;
    step();
    in_valid = 1'b0;
`ifdef ID_STAGE_ADDI_EN
    chk_out("addi", 1'b1, 5'd3, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0);
`else
    chk_out("addi", 1'b1, 5'd0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
`endif
    step();
    chk("illegal.dec_count", dec_count, 32'd10);

    // ADD with rd=x0 suppresses write-back, then flushed under backpressure
    out_ready = 1'b0; in_instr = 32'h00208033; rs1_data = 32'd5; rs2_data = 32'd7; in_valid = 1'b1;
    step();
    chk_out("add_rd0", 1'b1, 5'd3, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);
    flush = 1'b1; in_instr = 32'h000012B7;
    #1;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_out("flushed", 1'b0, 5'd0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);
    chk("flush.dec_count", dec_count, 32'd10);

    // Flush in a transfer cycle still counts the transfer
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("flush2.loaded", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flush2.out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush2.dec_count", dec_count, 32'd11);

    // Counter wrap on the next transfer
    force dut.dec_count_q = 32'hFFFFFFFF;
    #1;
    release dut.dec_count_q;
    chk("wrap.preset", dec_count, 32'hFFFFFFFF);
    in_valid = 1'b1; in_instr = 32'hABCDE337;
    step();
    in_valid = 1'b0;
    chk("wrap.load_only", dec_count, 32'hFFFFFFFF);
    step();
    chk("wrap.dec_count", dec_count, 32'h0);

    // Asynchronous reset while an instruction is held
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst.loaded", {31'd0, out_valid}, 32'd1);
    force dut.dec_count_q = 32'hFFFFFFFF;
    #1;
    release dut.dec_count_q;
    #1;
    rstn = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("rst_mid.dec_count", dec_count, 32'd0);
    chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("rst_after.out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
